riscv_commit_trace_buffer: RTL and testbench

- Synthesizable retirement-trace capture block for the RISC-V core verification environment.
- Samples the core's per-cycle retire stream (pc, instr, result, rd, regwrite) into a parametrised FIFO.
- Tags each qualified event with a sequence number and drains it to the scoreboard/monitor over a valid/ready handshake.
- Generalises the fixed 32-bit monitor signal set with configurable XLEN, depth and filter mode, plus overflow accounting.

---
 rtl/riscv_commit_trace_buffer.sv | 115 +++++++++++
 tb/tb_riscv_commit_trace_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_commit_trace_buffer.sv
// Retirement-trace capture FIFO: qualifies retire events, tags them with a
// sequence number and drains them over valid/ready with overflow accounting.
module riscv_commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       filter_mode,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_result,
    input  logic [4:0]                 in_rd,
    input  logic                       in_regwrite,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_result,
    output logic [4:0]                 out_rd,
    output logic                       out_regwrite,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [SEQ_W-1:0]           overflow_cnt,
    output logic                       overflow_sticky,
    input  logic                       clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  mem_pc     [DEPTH];
    logic [31:0]      mem_instr  [DEPTH];
    logic [XLEN-1:0]  mem_result [DEPTH];
    logic [4:0]       mem_rd     [DEPTH];
    logic             mem_rw     [DEPTH];
    logic [SEQ_W-1:0] mem_seq    [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [SEQ_W-1:0] seq;

    logic qualified;
    logic pop;
    logic push;
    logic drop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign out_valid = !empty;

    assign qualified = enable & in_valid & (filter_mode ? (in_regwrite & (in_rd != 5'd0)) : 1'b1);
    assign pop       = out_valid & out_ready;
    assign push      = qualified & (!full | pop);
    assign drop      = qualified & full & !pop;

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]     <= in_pc;
            mem_instr[wr_ptr]  <= in_instr;
            mem_result[wr_ptr] <= in_result;
            mem_rd[wr_ptr]     <= in_rd;
            mem_rw[wr_ptr]     <= in_regwrite;
            mem_seq[wr_ptr]    <= seq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            seq    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (qualified) seq <= seq + SEQ_W'(1);
        end
    end

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt    <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear_overflow) begin
            overflow_cnt    <= drop ? SEQ_W'(1) : '0;
            overflow_sticky <= drop;
        end else if (drop) begin
            if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + SEQ_W'(1);
            overflow_sticky <= 1'b1;
        end
    end

    assign out_pc       = out_valid ? mem_pc[rd_ptr]     : '0;
    assign out_instr    = out_valid ? mem_instr[rd_ptr]  : '0;
    assign out_result   = out_valid ? mem_result[rd_ptr] : '0;
    assign out_rd       = out_valid ? mem_rd[rd_ptr]     : '0;
    assign out_regwrite = out_valid ? mem_rw[rd_ptr]     : 1'b0;
    assign out_seq      = out_valid ? mem_seq[rd_ptr]    : '0;

endmodule

// File: tb/tb_riscv_commit_trace_buffer.sv
// Bench for riscv_commit_trace_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_riscv_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    logic              clk = 1'b0;
    logic              reset, enable, filter_mode, in_valid, in_regwrite, out_ready, clear_overflow;
    logic [XLEN-1:0]   in_pc, in_result;
    logic [31:0]       in_instr;
    logic [4:0]        in_rd;
    logic              out_valid, out_regwrite, full, empty, overflow_sticky;
    logic [XLEN-1:0]   out_pc, out_result;
    logic [31:0]       out_instr;
    logic [4:0]        out_rd;
    logic [SEQ_W-1:0]  out_seq, overflow_cnt;
    logic [$clog2(DEPTH):0] count;

    riscv_commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .filter_mode(filter_mode),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_result(in_result),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_result(out_result), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_seq(out_seq), .count(count), .full(full),
        .empty(empty), .overflow_cnt(overflow_cnt), .overflow_sticky(overflow_sticky),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
        logic [XLEN-1:0]  result;
        logic [4:0]       rd;
        logic             rw;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mq[$];
    logic [SEQ_W-1:0] m_seq;
    logic [SEQ_W-1:0] m_ovf;
    logic             m_sticky;
    bit               m_after_reset;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: applies one clock edge using the inputs sampled at that edge.
    task automatic model_update();
        bit qual, pop, drop, was_full;
        entry_t e;
        if (reset) begin
            mq.delete();
            m_seq = '0;
            m_ovf = '0;
            m_sticky = 1'b0;
            m_after_reset = 1;
            return;
        end
        m_after_reset = 0;
        qual     = enable && in_valid && (!filter_mode || (in_regwrite && in_rd != 0));
        pop      = (mq.size() > 0) && out_ready;
        was_full = (mq.size() == DEPTH);
        drop     = qual && was_full && !pop;
        if (pop) void'(mq.pop_front());
        if (qual && !drop) begin
            e.pc = in_pc; e.instr = in_instr; e.result = in_result;
            e.rd = in_rd; e.rw = in_regwrite; e.seq = m_seq;
            mq.push_back(e);
        end
        if (qual) m_seq = m_seq + 1'b1;
        if (clear_overflow) begin
            m_ovf    = drop ? 16'd1 : 16'd0;
            m_sticky = drop;
        end else if (drop) begin
            if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 1'b1;
            m_sticky = 1'b1;
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, mq.size() != 0);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("overflow_cnt", overflow_cnt, m_ovf);
        chk("overflow_sticky", overflow_sticky, m_sticky);
        if (mq.size() > 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_result", out_result, mq[0].result);
            chk("out_rd", out_rd, mq[0].rd);
            chk("out_regwrite", out_regwrite, mq[0].rw);
            chk("out_seq", out_seq, mq[0].seq);
        end else if (m_after_reset) begin
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_out_seq", out_seq, 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic retire(input logic [31:0] pc, input logic rw, input logic [4:0] rd);
        in_valid = 1'b1; in_pc = pc; in_instr = 32'h00000013 ^ pc;
        in_result = pc * 3 + 1; in_rd = rd; in_regwrite = rw;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; filter_mode = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; in_result = '0; in_rd = '0; in_regwrite = 1'b0;
        out_ready = 1'b0; clear_overflow = 1'b0;
        mq.delete(); m_seq = '0; m_ovf = '0; m_sticky = 1'b0; m_after_reset = 0;
        @(negedge clk);

        // In-order drain with latency 1
        do_reset();
        chk("t1_reset_valid", out_valid, 0);
        chk("t1_reset_empty", empty, 1);
        out_ready = 1'b1;
        retire(32'h0, 1'b1, 5'd1);
        chk("t1_first_valid", out_valid, 1);
        chk("t1_first_seq", out_seq, 0);
        retire(32'h4, 1'b1, 5'd2);
        chk("t1_second_seq", out_seq, 1);
        chk("t1_second_pc", out_pc, 32'h4);
        retire(32'h8, 1'b1, 5'd3);
        chk("t1_third_seq", out_seq, 2);
        step();
        chk("t1_end_empty", empty, 1);

        // Filter mode
        do_reset();
        out_ready = 1'b0; filter_mode = 1'b1;
        retire(32'h100, 1'b1, 5'd5);
        retire(32'h104, 1'b0, 5'd6);
        retire(32'h108, 1'b1, 5'd0);
        retire(32'h10c, 1'b1, 5'd7);
        chk("t2_count", count, 2);
        chk("t2_head_rd", out_rd, 5);
        chk("t2_head_seq", out_seq, 0);
        out_ready = 1'b1; step();
        chk("t2_next_rd", out_rd, 7);
        chk("t2_next_seq", out_seq, 1);
        step();
        filter_mode = 1'b0;

        // Overflow with 20 retires into 16 entries
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) retire(32'h1000 + 4 * i, 1'b1, 5'd9);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow_cnt, 4);
        chk("t3_sticky", overflow_sticky, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_seq", out_seq, i);
            step();
        end
        out_ready = 1'b0;
        retire(32'h2000, 1'b1, 5'd4);
        chk("t3_next_seq", out_seq, 20);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 15; i++) retire(32'h3000 + 4 * i, 1'b0, 5'd3);
        chk("t4_full", count, 16);
        out_ready = 1'b1;
        retire(32'h4000, 1'b1, 5'd8);
        chk("t4_count_kept", count, 16);
        chk("t4_no_drop", overflow_cnt, 4);
        out_ready = 1'b0;

        // Drop and clear in the same cycle
        do_reset();
        for (int i = 0; i < 21; i++) retire(32'h5000 + 4 * i, 1'b1, 5'd1);
        chk("t5_ovf5", overflow_cnt, 5);
        clear_overflow = 1'b1;
        retire(32'h6000, 1'b1, 5'd1);
        chk("t5_clear_drop_cnt", overflow_cnt, 1);
        chk("t5_clear_drop_sticky", overflow_sticky, 1);
        step();
        clear_overflow = 1'b0;
        chk("t5_clear_cnt", overflow_cnt, 0);
        chk("t5_clear_sticky", overflow_sticky, 0);

        // Reset mid-traffic
        do_reset();
        for (int i = 0; i < 18; i++) retire(32'h7000 + 4 * i, 1'b1, 5'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        out_ready = 1'b0;
        chk("t6_count7", count, 7);
        chk("t6_ovf2", overflow_cnt, 2);
        do_reset();
        chk("t6_rst_count", count, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ovf", overflow_cnt, 0);
        retire(32'h8000, 1'b1, 5'd2);
        chk("t6_seq0", out_seq, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable         = ($urandom_range(0, 9) != 0);
            filter_mode    = ($urandom_range(0, 3) == 0);
            in_valid       = ($urandom_range(0, 3) != 0);
            in_pc          = $urandom;
            in_instr       = $urandom;
            in_result      = $urandom;
            in_rd          = 5'($urandom_range(0, 3));
            in_regwrite    = $urandom_range(0, 1);
            out_ready      = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 3 : 8));
            clear_overflow = ($urandom_range(0, 49) == 0);
            reset          = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; in_valid = 1'b0; clear_overflow = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
